page_mem_arb: RTL and testbench

Round-robin arbiter sharing the single-port byte-wide page memory between its requesters: the input parser's page writer, the page sorter, and the middle-value summer. It grants one access per cycle and drives the memory port from the granted requester. It also provides a lock, so the sorter can hold the port across a multi-cycle read/swap sequence. A watchdog force-releases a lock that is held too long.

---
 rtl/page_mem_arb.sv | 170 +++++++++++++++++
 tb/tb_page_mem_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_mem_arb.sv
// page_mem_arb
// Round-robin arbiter for the shared single-port byte-wide page memory.
// Requester 0 is the page writer, 1 the page sorter and 2 the middle-value summer.
// One access is granted per cycle, and the memory port is driven from the winner.
// A requester can lock the port across several accesses. A watchdog breaks a
// lock that is held too long and raises a sticky error flag.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   req/we/lock    per-requester request, write enable and keep-ownership flag
//   addr/wdata     packed per-requester address and write data
//   gnt            one-hot grant, combinational; accepted when req[i] & gnt[i]
//   rvalid/rdata   read response, one cycle after an accepted read
//   mem_*          memory port (mem_data_out is valid the cycle after the address)
//   lock_err       sticky watchdog flag, cleared only by rst
module page_mem_arb #(
  parameter int NREQ     = 3,
  parameter int AW       = 32,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_data_in,
  input  logic [DW-1:0]      mem_data_out,
  output logic               lock_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [NREQ-1:0] rvalid_reg, rvalid_next;
  logic            lock_err_reg, lock_err_next;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   scan_idx;
  logic            accept;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[gi*AW +: AW];
    assign wdata_arr[gi] = wdata[gi*DW +: DW];
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Grant selection. Nothing depends on mem_data_out here, so there is no
  // combinational path from the memory back into gnt.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = ptr_reg;
    if (!rst) begin
      if (state_reg == LOCKED) begin
        // Only the owner is considered; an idle owner simply leaves the port unused.
        if (req[owner_reg]) begin
          gnt_any = 1'b1;
          gnt_idx = owner_reg;
        end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!gnt_any && req[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
          end
          scan_idx = wrap_inc(scan_idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign accept = gnt_any & req[gnt_idx];

  // Memory port follows the winner; it is zeroed when nobody is granted.
  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (gnt_any) begin
      mem_we      = accept & we[gnt_idx];
      mem_addr    = addr_arr[gnt_idx];
      mem_data_in = wdata_arr[gnt_idx];
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    lock_cnt_next = lock_cnt_reg;
    lock_err_next = lock_err_reg;
    rvalid_next   = '0;

    if (accept && !we[gnt_idx]) rvalid_next[gnt_idx] = 1'b1;

    if (state_reg == IDLE) begin
      if (accept) begin
        if (lock[gnt_idx]) begin
          // ptr is left alone; it advances past the owner when the lock ends.
          state_next    = LOCKED;
          owner_next    = gnt_idx;
          lock_cnt_next = '0;
        end else begin
          ptr_next = wrap_inc(gnt_idx);
        end
      end
    end else begin
      lock_cnt_next = lock_cnt_reg + 1'b1;
      // A voluntary release wins over the watchdog in the same cycle.
      if (!lock[owner_reg]) begin
        state_next = IDLE;
        ptr_next   = wrap_inc(owner_reg);
      end else if ((LOCK_MAX != 0) && (lock_cnt_reg == CW'(LOCK_MAX - 1))) begin
        state_next    = IDLE;
        ptr_next      = wrap_inc(owner_reg);
        lock_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      lock_cnt_reg <= '0;
      rvalid_reg   <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      lock_cnt_reg <= lock_cnt_next;
      rvalid_reg   <= rvalid_next;
      lock_err_reg <= lock_err_next;
    end
  end

  assign rvalid   = rvalid_reg;
  assign lock_err = lock_err_reg;
  assign rdata    = mem_data_out;

endmodule

// File: tb/tb_page_mem_arb.sv
// tb_page_mem_arb
// Self-checking bench for page_mem_arb (built with LOCK_MAX=4 so the watchdog
// is reachable). A 256-byte memory model sits on the memory port. A behavioural
// model of the arbitration rules predicts every output each cycle.
module tb_page_mem_arb;
  localparam int NREQ     = 3;
  localparam int AW       = 32;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, we, lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_data_in;
  logic [DW-1:0]      mem_data_out;
  logic               lock_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_locked = 0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  int          m_cnt    = 0;
  bit          m_err    = 0;
  int          m_rv     = -1;
  logic [7:0]  m_rv_data = '0;
  logic [7:0]  shadow [256];
  logic [7:0]  mem    [256];

  logic [2:0]  rr_exp [6];

  page_mem_arb #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, read-before-write
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which requester the rules say wins this cycle, or -1
  function automatic int model_win();
    int i;
    if (rst) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // Compare all outputs against the model, away from the active edge
  task automatic probe();
    int win;
    logic [2:0]  exp_g;
    logic        exp_we;
    logic [31:0] exp_a;
    logic [7:0]  exp_d;
    @(negedge clk);
    win    = model_win();
    exp_g  = '0;
    exp_we = 1'b0;
    exp_a  = '0;
    exp_d  = '0;
    if (win >= 0) begin
      exp_g  = 3'(1 << win);
      exp_we = we[win];
      exp_a  = addr[win*AW +: AW];
      exp_d  = wdata[win*DW +: DW];
    end
    chk("gnt", gnt, exp_g);
    chk("mem_we", mem_we, exp_we);
    chk("mem_addr", mem_addr, exp_a);
    chk("mem_data_in", mem_data_in, exp_d);
    if (rst) begin
      chk("rvalid_in_rst", rvalid, 0);
      chk("lock_err_in_rst", lock_err, 0);
    end else begin
      chk("rvalid", rvalid, (m_rv >= 0) ? 3'(1 << m_rv) : 3'b000);
      if (m_rv >= 0) chk("rdata", rdata, m_rv_data);
      chk("lock_err", lock_err, m_err);
    end
  endtask

  // Advance the model across the rising edge
  task automatic tick();
    int win;
    win = model_win();
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_rv = -1;
    end else begin
      m_rv = -1;
      if (win >= 0) begin
        if (we[win]) shadow[addr[win*AW +: 8]] = wdata[win*DW +: DW];
        else begin
          m_rv      = win;
          m_rv_data = shadow[addr[win*AW +: 8]];
        end
      end
      if (m_locked) begin
        if (!lock[m_owner]) begin
          m_locked = 0;
          m_ptr    = (m_owner + 1) % NREQ;
        end else if (m_cnt == LOCK_MAX - 1) begin
          m_locked = 0;
          m_ptr    = (m_owner + 1) % NREQ;
          m_err    = 1;
        end else begin
          m_cnt++;
        end
      end else if (win >= 0) begin
        if (lock[win]) begin
          m_locked = 1;
          m_owner  = win;
          m_cnt    = 0;
        end else begin
          m_ptr = (win + 1) % NREQ;
        end
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    probe();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    // Reset state: requests are ignored while rst is high
    req = 3'b111;
    probe();
    chk("rst_gnt", gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();
    rst = 1'b0;
    req = 3'b001;
    addr = {32'd0, 32'd0, 32'd5};
    probe();
    chk("post_rst_gnt", gnt, 3'b001);
    tick();

    // Reset raised while a read is being accepted: no rvalid afterwards
    req = 3'b010;
    addr = {32'd0, 32'd7, 32'd0};
    probe();
    #1 rst = 1'b1;
    tick();
    req = 3'b111;
    probe();
    chk("rst_rvalid_drop", rvalid, 0);
    chk("rst_lock_err", lock_err, 0);
    tick();
    rst = 1'b0;
    req = 3'b001;
    probe();
    chk("rst_release_gnt", gnt, 3'b001);
    tick();

    // Round robin over three readers
    pulse_reset();
    req  = 3'b111;
    we   = 3'b000;
    addr = {32'd30, 32'd20, 32'd10};
    for (int k = 0; k < 6; k++) begin
      probe();
      chk("rr_gnt", gnt, rr_exp[k]);
      if (k > 0) chk("rr_rvalid", rvalid, rr_exp[k-1]);
      tick();
    end
    req = 3'b000;
    probe();
    chk("rr_last_rvalid", rvalid, 3'b100);
    tick();

    // Writer stores 2A at 64, summer reads it back
    req = 3'b001; we = 3'b001; addr = {32'd0, 32'd0, 32'd64}; wdata = {8'h00, 8'h00, 8'h2A};
    probe();
    chk("wr_mem_we", mem_we, 1);
    tick();
    req = 3'b100; we = 3'b000; addr = {32'd64, 32'd0, 32'd0};
    probe();
    chk("wr_no_rvalid", rvalid, 0);
    tick();
    req = 3'b000;
    probe();
    chk("rd_rvalid", rvalid, 3'b100);
    chk("rd_rdata", rdata, 8'h2A);
    tick();

    // Sorter lock for five cycles against competing requesters
    req = 3'b001; addr = {32'd30, 32'd20, 32'd10};
    probe(); tick();
    req = 3'b111; lock = 3'b010;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) lock = 3'b000;
      probe();
      chk("lock_gnt", gnt, 3'b010);
      tick();
    end
    req = 3'b101;
    probe();
    chk("lock_next_gnt", gnt, 3'b100);
    tick();

    // Watchdog: sorter never releases
    req = 3'b001;
    probe(); tick();
    req = 3'b111; lock = 3'b010;
    for (int k = 0; k < 5; k++) begin
      probe();
      chk("wd_gnt", gnt, 3'b010);
      tick();
    end
    probe();
    chk("wd_err", lock_err, 1);
    chk("wd_gnt_after", gnt, 3'b100);
    tick();
    lock = 3'b000;
    probe();
    chk("wd_gnt_w", gnt, 3'b001);
    tick();
    probe();
    chk("wd_gnt_s", gnt, 3'b010);
    chk("wd_err_sticky", lock_err, 1);
    tick();

    // Owner keeps the lock without requesting; writer must wait
    req = 3'b010; lock = 3'b010;
    probe(); tick();
    req = 3'b001;
    for (int k = 0; k < 3; k++) begin
      probe();
      chk("idle_own_gnt", gnt, 0);
      chk("idle_own_we", mem_we, 0);
      if (k > 0) chk("idle_own_rvalid", rvalid, 0);
      tick();
    end
    lock = 3'b000;
    probe();
    chk("idle_own_release_gnt", gnt, 0);
    tick();
    probe();
    chk("idle_own_served", gnt, 3'b001);
    tick();

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = 3'($urandom);
      we   = 3'($urandom);
      lock = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      for (int i = 0; i < NREQ; i++) begin
        addr[i*AW +: AW]  = 32'($urandom_range(0, 255));
        wdata[i*DW +: DW] = 8'($urandom);
      end
      probe();
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
